// File: rtl/id_issue_queue.sv
// Decode-to-issue queue: circular buffer that presents the oldest ISSUE_PORTS
// entries in order and retires a contiguous prefix of acknowledged ports.
module id_issue_queue #(
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned ISSUE_PORTS  = 2,
    parameter int unsigned CF_SERIALISE = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic [DATA_W-1:0]             decoded_i,
    input  logic [31:0]                   orig_instr_i,
    input  logic                          is_ctrl_flow_i,
    input  logic                          decoded_valid_i,
    output logic                          decoded_ready_o,
    output logic [ISSUE_PORTS*DATA_W-1:0] issue_entry_o,
    output logic [ISSUE_PORTS*32-1:0]     orig_instr_o,
    output logic [ISSUE_PORTS-1:0]        is_ctrl_flow_o,
    output logic [ISSUE_PORTS-1:0]        issue_entry_valid_o,
    input  logic [ISSUE_PORTS-1:0]        issue_instr_ack_i,
    output logic [$clog2(DEPTH+1)-1:0]    count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [DATA_W-1:0] data_q  [DEPTH];
    logic [31:0]       instr_q [DEPTH];
    logic [DEPTH-1:0]  cf_q;

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] acked;
    logic [PW-1:0] idx;
    logic          blocked;
    logic          run;
    logic          hit;
    logic          ack_gap;
    logic          wr_en;

    // Port k shows entry rd_ptr+k; a held control-flow entry hides all younger ports.
    always_comb begin
        issue_entry_o       = '0;
        orig_instr_o        = '0;
        is_ctrl_flow_o      = '0;
        issue_entry_valid_o = '0;
        blocked             = 1'b0;
        idx                 = '0;
        for (int unsigned k = 0; k < ISSUE_PORTS; k++) begin
            idx = rd_ptr_q + PW'(k);
            issue_entry_o[k*DATA_W +: DATA_W] = data_q[idx];
            orig_instr_o[k*32 +: 32]          = instr_q[idx];
            is_ctrl_flow_o[k]                 = cf_q[idx];
            issue_entry_valid_o[k]            = (count_q > CW'(k)) && !blocked;
            if ((CF_SERIALISE != 0) && cf_q[idx]) begin
                blocked = 1'b1;
            end
        end
    end

    always_comb begin
        acked   = '0;
        run     = 1'b1;
        hit     = 1'b0;
        ack_gap = 1'b0;
        for (int unsigned k = 0; k < ISSUE_PORTS; k++) begin
            hit = issue_instr_ack_i[k] && issue_entry_valid_o[k];
            if (hit && run) begin
                acked = acked + CW'(1);
            end else begin
                if (hit) begin
                    ack_gap = 1'b1;
                end
                run = 1'b0;
            end
        end
    end

    // Slots freed by this cycle's acks count as space, so a full queue can still accept.
    assign decoded_ready_o = !flush_i && ((count_q - acked) < CW'(DEPTH));
    assign wr_en           = decoded_valid_i && decoded_ready_o;
    assign count_o         = count_q;

    always_comb begin
        if (flush_i) begin
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
            wr_ptr_d = wr_ptr_q;
        end else begin
            count_d  = count_q + CW'(wr_en) - acked;
            rd_ptr_d = rd_ptr_q + PW'(acked);
            wr_ptr_d = wr_ptr_q + PW'(wr_en);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            data_q[wr_ptr_q]  <= decoded_i;
            instr_q[wr_ptr_q] <= orig_instr_i;
            cf_q[wr_ptr_q]    <= is_ctrl_flow_i;
        end
    end

    ack_contiguous_a: assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i) !ack_gap);
    count_bound_a:    assert property (@(posedge clk_i) disable iff (!rst_ni) count_q <= CW'(DEPTH));

endmodule

// File: tb/tb_id_issue_queue.sv
// Directed bench for id_issue_queue with a queue-based reference of held entries.
module tb_id_issue_queue;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         flush_i;
    logic [63:0]  decoded_i;
    logic [31:0]  orig_instr_i;
    logic         is_ctrl_flow_i;
    logic         decoded_valid_i;
    logic         decoded_ready_o;
    logic [127:0] issue_entry_o;
    logic [63:0]  orig_instr_o;
    logic [1:0]   is_ctrl_flow_o;
    logic [1:0]   issue_entry_valid_o;
    logic [1:0]   issue_instr_ack_i;
    logic [2:0]   count_o;

    int checks   = 0;
    int failures = 0;
    int sn       = 0;

    typedef struct {
        logic [63:0] d;
        logic [31:0] i;
        logic        cf;
    } ent_t;
    ent_t sb[$];

    always #5 clk_i = ~clk_i;

    id_issue_queue #(
        .DATA_W      (64),
        .DEPTH       (4),
        .ISSUE_PORTS (2),
        .CF_SERIALISE(1)
    ) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .flush_i            (flush_i),
        .decoded_i          (decoded_i),
        .orig_instr_i       (orig_instr_i),
        .is_ctrl_flow_i     (is_ctrl_flow_i),
        .decoded_valid_i    (decoded_valid_i),
        .decoded_ready_o    (decoded_ready_o),
        .issue_entry_o      (issue_entry_o),
        .orig_instr_o       (orig_instr_o),
        .is_ctrl_flow_o     (is_ctrl_flow_o),
        .issue_entry_valid_o(issue_entry_valid_o),
        .issue_instr_ack_i  (issue_instr_ack_i),
        .count_o            (count_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_valid();
        logic [1:0] v;
        v[0] = sb.size() > 0;
        v[1] = (sb.size() > 1) && !sb[0].cf;
        return v;
    endfunction

    task automatic check_state(input string tag);
        logic [1:0] v;
        v = exp_valid();
        chk({tag, ".count"}, 64'(count_o), 64'(sb.size()));
        chk({tag, ".valid"}, 64'(issue_entry_valid_o), 64'(v));
        for (int k = 0; k < 2; k++) begin
            if (v[k]) begin
                chk({tag, ".data"},  issue_entry_o[k*64 +: 64],    sb[k].d);
                chk({tag, ".instr"}, 64'(orig_instr_o[k*32 +: 32]), 64'(sb[k].i));
                chk({tag, ".cf"},    64'(is_ctrl_flow_o[k]),       64'(sb[k].cf));
            end
        end
    endtask

    // Entered at posedge+1; checks at posedge+2; commits at the next posedge.
    task automatic cycle(input string tag, input logic vld, input logic cf,
                         input logic [1:0] ack, input logic flush);
        logic [1:0] v;
        int         nack;
        logic       rdy;
        ent_t       e;
        e.d  = {32'hD00D_0000 | 32'(sn), 32'(sn) * 32'h9E37_79B9};
        e.i  = 32'h1300_0000 | 32'(sn);
        e.cf = cf;
        decoded_valid_i   = vld;
        decoded_i         = e.d;
        orig_instr_i      = e.i;
        is_ctrl_flow_i    = cf;
        issue_instr_ack_i = ack;
        flush_i           = flush;
        #1;
        check_state(tag);
        v    = exp_valid();
        nack = 0;
        if (ack[0] && v[0]) begin
            nack = 1;
            if (ack[1] && v[1]) nack = 2;
        end
        rdy = !flush && ((sb.size() - nack) < 4);
        chk({tag, ".ready"}, 64'(decoded_ready_o), 64'(rdy));
        if (flush) begin
            sb.delete();
        end else begin
            for (int k = 0; k < nack; k++) void'(sb.pop_front());
            if (vld && rdy) begin
                sb.push_back(e);
                sn++;
            end
        end
        @(posedge clk_i);
        #1;
        decoded_valid_i   = 1'b0;
        issue_instr_ack_i = 2'b00;
        flush_i           = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 8 && sb.size() > 0; n++) cycle(tag, 1'b0, 1'b0, 2'b11, 1'b0);
        chk({tag, ".empty"}, 64'(count_o), 64'd0);
    endtask

    initial begin
        rst_ni            = 1'b1;
        flush_i           = 1'b0;
        decoded_i         = '0;
        orig_instr_i      = '0;
        is_ctrl_flow_i    = 1'b0;
        decoded_valid_i   = 1'b0;
        issue_instr_ack_i = 2'b00;
        #2 rst_ni = 1'b0;
        #1;
        chk("rst.count", 64'(count_o), 64'd0);
        chk("rst.valid", 64'(issue_entry_valid_o), 64'd0);
        chk("rst.ready", 64'(decoded_ready_o), 64'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Fill to capacity, no acks
        for (int n = 0; n < 4; n++) cycle("fill", 1'b1, 1'b0, 2'b00, 1'b0);
        cycle("full", 1'b1, 1'b0, 2'b00, 1'b0);
        chk("full.count", 64'(count_o), 64'd4);

        // Full queue accepts while port 0 is acked
        cycle("fullack", 1'b1, 1'b0, 2'b01, 1'b0);
        chk("fullack.count", 64'(count_o), 64'd4);
        cycle("fullack.post", 1'b0, 1'b0, 2'b00, 1'b0);
        drain("drain1");

        // Streaming with dual acks across pointer wrap
        for (int n = 0; n < 6; n++) cycle("wrap", 1'b1, 1'b0, 2'b11, 1'b0);
        drain("drain2");

        // Control-flow on port 0 hides port 1
        cycle("cf.w0", 1'b1, 1'b1, 2'b00, 1'b0);
        cycle("cf.w1", 1'b1, 1'b0, 2'b00, 1'b0);
        chk("cf.valid", 64'(issue_entry_valid_o), 64'd1);
        cycle("cf.ack", 1'b0, 1'b0, 2'b01, 1'b0);
        chk("cf.after", 64'(issue_entry_valid_o), 64'd1);
        // Control-flow on port 1 does not block itself
        cycle("cf.w2", 1'b1, 1'b1, 2'b00, 1'b0);
        chk("cf.port1", 64'(issue_entry_valid_o), 64'd3);
        drain("drain3");

        // Flush with simultaneous write and dual ack
        for (int n = 0; n < 3; n++) cycle("pref", 1'b1, 1'b0, 2'b00, 1'b0);
        cycle("flush", 1'b1, 1'b0, 2'b11, 1'b1);
        cycle("flush.post", 1'b0, 1'b0, 2'b00, 1'b0);
        chk("flush.valid", 64'(issue_entry_valid_o), 64'd0);
        cycle("flush.w", 1'b1, 1'b0, 2'b00, 1'b0);
        cycle("flush.rd", 1'b0, 1'b0, 2'b00, 1'b0);
        drain("drain4");

        // Asynchronous reset between clock edges
        for (int n = 0; n < 2; n++) cycle("prer", 1'b1, 1'b0, 2'b00, 1'b0);
        chk("prer.count", 64'(count_o), 64'd2);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst.count", 64'(count_o), 64'd0);
        chk("arst.valid", 64'(issue_entry_valid_o), 64'd0);
        sb.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        cycle("postr.w", 1'b1, 1'b0, 2'b00, 1'b0);
        cycle("postr.rd", 1'b0, 1'b0, 2'b01, 1'b0);
        cycle("postr.end", 1'b0, 1'b0, 2'b00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
